// File: rtl/multi_port_free_list.sv
// Multi-port physical register free list: circular queue with all-or-nothing allocation and packed releases.
// Optional output free_count is enabled by defining FREE_LIST_COUNT_EN.
module multi_port_free_list #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned PHYS_WIDTH = 6,
  parameter int unsigned DEQ_PORTS  = 2,
  parameter int unsigned ENQ_PORTS  = 2,
  parameter int unsigned RESET_BASE = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned CW         = ADDR_WIDTH + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ENQ_PORTS-1:0]                 enq_valid,
  input  logic [ENQ_PORTS-1:0][PHYS_WIDTH-1:0] enq_preg,
  input  logic [DEQ_PORTS-1:0]                 deq_req,
  output logic [DEQ_PORTS-1:0][PHYS_WIDTH-1:0] deq_preg,
  output logic                                 deq_grant,
  input  logic                                 br_flush,
  input  logic [CW-1:0]                        rollback_head,
  output logic [CW-1:0]                        head_out,
`ifdef FREE_LIST_COUNT_EN
  output logic [CW-1:0]                        free_count,
`endif
  output logic                                 fl_empty,
  output logic                                 fl_full
);

  logic [PHYS_WIDTH-1:0] r_queue [DEPTH];
  logic [CW-1:0]         r_head;
  logic [CW-1:0]         r_tail;

  logic [CW-1:0]         w_occ;
  logic [CW-1:0]         w_reqCnt;
  logic [CW-1:0]         w_popCnt;
  logic [CW-1:0]         w_space;
  logic [CW-1:0]         w_enqCnt;
  logic [CW-1:0]         w_deqRank [DEQ_PORTS];
  logic [CW-1:0]         w_enqRank [ENQ_PORTS];
  logic [ADDR_WIDTH-1:0] w_deqIdx  [DEQ_PORTS];
  logic [ADDR_WIDTH-1:0] w_enqIdx  [ENQ_PORTS];
  logic [ENQ_PORTS-1:0]  w_enqAcc;

  assign w_occ    = r_tail - r_head;
  assign fl_empty = (w_occ == '0);
  assign fl_full  = (r_head[ADDR_WIDTH-1:0] == r_tail[ADDR_WIDTH-1:0]) &&
                    (r_head[ADDR_WIDTH] != r_tail[ADDR_WIDTH]);
  assign head_out = r_head;

`ifdef FREE_LIST_COUNT_EN
  assign free_count = w_occ;
`endif

  // Allocation: each requesting lane takes the next entry after all lower requesting lanes.
  always_comb begin
    w_reqCnt = '0;
    for (int i = 0; i < DEQ_PORTS; i++) begin
      w_deqRank[i] = w_reqCnt;
      if (deq_req[i]) w_reqCnt = w_reqCnt + CW'(1);
    end
    deq_grant = (w_reqCnt <= w_occ);
    w_popCnt  = deq_grant ? w_reqCnt : '0;
    for (int i = 0; i < DEQ_PORTS; i++) begin
      w_deqIdx[i] = r_head[ADDR_WIDTH-1:0] + ADDR_WIDTH'(w_deqRank[i]);
      deq_preg[i] = (deq_req[i] && deq_grant) ? r_queue[w_deqIdx[i]] : '0;
    end
  end

  // A flush discards this cycle's pop, so only real pops free up room for releases.
  always_comb begin
    w_space  = CW'(DEPTH) - w_occ + (br_flush ? '0 : w_popCnt);
    w_enqCnt = '0;
    w_enqAcc = '0;
    for (int j = 0; j < ENQ_PORTS; j++) begin
      w_enqRank[j] = w_enqCnt;
      w_enqIdx[j]  = r_tail[ADDR_WIDTH-1:0] + ADDR_WIDTH'(w_enqCnt);
      if (enq_valid[j] && (w_enqCnt < w_space)) begin
        w_enqAcc[j] = 1'b1;
        w_enqCnt    = w_enqCnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= CW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        r_queue[i] <= PHYS_WIDTH'(RESET_BASE + i);
      end
    end else begin
      if (br_flush) begin
        r_head <= rollback_head;
      end else if (deq_grant) begin
        r_head <= r_head + w_reqCnt;
      end
      r_tail <= r_tail + w_enqCnt;
      for (int j = 0; j < ENQ_PORTS; j++) begin
        if (w_enqAcc[j]) r_queue[w_enqIdx[j]] <= enq_preg[j];
      end
    end
  end

endmodule

// File: tb/tb_multi_port_free_list.sv
// Directed testbench for multi_port_free_list (default build, FREE_LIST_COUNT_EN undefined).
module tb_multi_port_free_list;

  logic            clk;
  logic            rst;
  logic [1:0]      enq_valid;
  logic [1:0][5:0] enq_preg;
  logic [1:0]      deq_req;
  logic [1:0][5:0] deq_preg;
  logic            deq_grant;
  logic            br_flush;
  logic [5:0]      rollback_head;
  logic [5:0]      head_out;
  logic            fl_empty;
  logic            fl_full;

  int checks;
  int failures;

  multi_port_free_list dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_preg      (enq_preg),
    .deq_req       (deq_req),
    .deq_preg      (deq_preg),
    .deq_grant     (deq_grant),
    .br_flush      (br_flush),
    .rollback_head (rollback_head),
    .head_out      (head_out),
    .fl_empty      (fl_empty),
    .fl_full       (fl_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] req, input logic [1:0] ev,
                               input logic [5:0] p1, input logic [5:0] p0,
                               input logic fl, input logic [5:0] rb);
    rst           = r;
    deq_req       = req;
    enq_valid     = ev;
    enq_preg[1]   = p1;
    enq_preg[0]   = p0;
    br_flush      = fl;
    rollback_head = rb;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    tick();
    tick();
    applyStimulus(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);

    // Reset state
    checkOutput("rst_full", fl_full, 1);
    checkOutput("rst_empty", fl_empty, 0);
    checkOutput("rst_head", head_out, 0);
    checkOutput("rst_grant", deq_grant, 1);
    checkOutput("rst_preg0", deq_preg[0], 0);
    checkOutput("rst_preg1", deq_preg[1], 0);

    // Dual allocation straight after reset
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("dual_grant", deq_grant, 1);
    checkOutput("dual_preg0", deq_preg[0], 32);
    checkOutput("dual_preg1", deq_preg[1], 33);
    tick();
    checkOutput("dual_head", head_out, 2);

    // Sparse request: only lane 1 asks
    doReset();
    applyStimulus(1'b0, 2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("sparse_preg1", deq_preg[1], 32);
    checkOutput("sparse_preg0", deq_preg[0], 0);
    tick();
    checkOutput("sparse_head", head_out, 1);

    // Drain to occupancy 1, then ask for two
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    for (int k = 0; k < 15; k++) tick();
    checkOutput("drain_head", head_out, 31);
    checkOutput("drain_empty", fl_empty, 0);
    checkOutput("short_grant", deq_grant, 0);
    checkOutput("short_preg0", deq_preg[0], 0);
    checkOutput("short_preg1", deq_preg[1], 0);
    tick();
    checkOutput("short_head_hold", head_out, 31);
    applyStimulus(1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("last_grant", deq_grant, 1);
    checkOutput("last_preg0", deq_preg[0], 63);
    tick();
    checkOutput("last_empty", fl_empty, 1);
    checkOutput("last_full", fl_full, 0);

    // Empty list with a same-cycle release: no bypass
    applyStimulus(1'b0, 2'b01, 2'b01, 6'd0, 6'd12, 1'b0, 6'd0);
    checkOutput("bypass_grant", deq_grant, 0);
    checkOutput("bypass_preg0", deq_preg[0], 0);
    tick();
    applyStimulus(1'b0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("bypass_head", head_out, 32);
    checkOutput("after_grant", deq_grant, 1);
    checkOutput("after_preg0", deq_preg[0], 12);
    tick();
    checkOutput("after_head", head_out, 33);
    checkOutput("after_empty", fl_empty, 1);

    // Wrap: 32 pops then a two-lane release
    doReset();
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    for (int k = 0; k < 16; k++) tick();
    applyStimulus(1'b0, 2'b00, 2'b11, 6'd5, 6'd7, 1'b0, 6'd0);
    checkOutput("wrap_head", head_out, 32);
    checkOutput("wrap_empty", fl_empty, 1);
    tick();
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("wrap_grant", deq_grant, 1);
    checkOutput("wrap_preg0", deq_preg[0], 7);
    checkOutput("wrap_preg1", deq_preg[1], 5);
    tick();
    checkOutput("wrap_head2", head_out, 34);
    checkOutput("wrap_empty2", fl_empty, 1);

    // Branch flush overrides a pop while a release still commits
    doReset();
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    tick();
    tick();
    checkOutput("ckpt_head", head_out, 4);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("pre_flush_head", head_out, 10);
    applyStimulus(1'b0, 2'b11, 2'b01, 6'd0, 6'd9, 1'b1, 6'd4);
    tick();
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("flush_head", head_out, 4);
    checkOutput("flush_full", fl_full, 0);
    checkOutput("flush_preg0", deq_preg[0], 36);
    checkOutput("flush_preg1", deq_preg[1], 37);
    tick();
    checkOutput("flush_head2", head_out, 6);

    // Reset wins over flush, pop and release mid-operation
    applyStimulus(1'b1, 2'b11, 2'b11, 6'd1, 6'd2, 1'b1, 6'd20);
    tick();
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("prio_full", fl_full, 1);
    checkOutput("prio_preg0", deq_preg[0], 32);
    checkOutput("prio_preg1", deq_preg[1], 33);
    tick();
    checkOutput("prio_head", head_out, 2);

    // Releases into a full list are dropped
    doReset();
    applyStimulus(1'b0, 2'b00, 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
    tick();
    applyStimulus(1'b0, 2'b11, 2'b11, 6'd3, 6'd4, 1'b0, 6'd0);
    checkOutput("drop_full", fl_full, 1);
    checkOutput("drop_preg0", deq_preg[0], 32);
    checkOutput("drop_preg1", deq_preg[1], 33);
    tick();
    applyStimulus(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("swap_full", fl_full, 1);
    checkOutput("swap_head", head_out, 2);

    // One pop frees one slot: only release lane 0 is accepted
    doReset();
    applyStimulus(1'b0, 2'b01, 2'b11, 6'd21, 6'd20, 1'b0, 6'd0);
    checkOutput("partial_preg0", deq_preg[0], 32);
    tick();
    applyStimulus(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 6'd0);
    checkOutput("partial_full", fl_full, 1);
    checkOutput("partial_head", head_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_port_free_list.md
MULTI_PORT_FREE_LIST -- requirements
Module: multi_port_free_list

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of free-list entries; power of two, >= 4.
REQ-002 SHALL have parameter PHYS_WIDTH, default 6, physical register index width.
REQ-003 SHALL have parameter DEQ_PORTS, default 2, allocation lanes per cycle (1..4).
REQ-004 SHALL have parameter ENQ_PORTS, default 2, release lanes per cycle (1..4).
REQ-005 SHALL have parameter RESET_BASE, default 32, first physical register index loaded at reset.
REQ-006 SHALL derive ADDR_WIDTH = clog2(DEPTH); pointers are ADDR_WIDTH+1 bits, MSB is the wrap bit.
REQ-007 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have: enq_valid  in  ENQ_PORTS  per-lane release strobe from the retire stage.
REQ-009 SHALL have: enq_preg  in  ENQ_PORTS x PHYS_WIDTH  released register per lane.
REQ-010 SHALL have: deq_req  in  DEQ_PORTS  per-lane allocation request from dispatch.
REQ-011 SHALL have: deq_preg  out  DEQ_PORTS x PHYS_WIDTH  allocated register per lane.
REQ-012 SHALL have: deq_grant  out  1  all requested lanes served this cycle.
REQ-013 SHALL have: br_flush  in  1  mispredict recovery; rollback_head  in  ADDR_WIDTH+1  checkpointed head.
REQ-014 SHALL have: head_out  out  ADDR_WIDTH+1  current head, for checkpointing at branch dispatch.
REQ-015 SHALL have: fl_empty  out  1; fl_full  out  1.

Function
REQ-016 SHALL compute occupancy = tail - head (ADDR_WIDTH+1 bit modular); fl_empty = occupancy==0; fl_full = low bits equal and wrap bits differ.
REQ-017 SHALL grant all-or-nothing: deq_grant=1 iff popcount(deq_req) <= occupancy; any zero-request cycle gives deq_grant=1.
REQ-018 SHALL serve granted lane i from queue[head + count of requesting lanes below i], combinationally, same cycle; pop uses pre-enqueue occupancy (no enqueue-to-dequeue bypass).
REQ-019 SHALL drive deq_preg lane to 0 when that lane is not requesting or deq_grant=0.
REQ-020 SHALL advance head by popcount(deq_req) on the clock edge when deq_grant=1; otherwise hold.
REQ-021 SHALL write valid release lanes packed in lane order to queue[tail + rank] and advance tail by the number accepted.
REQ-022 SHALL accept release lanes in lane order only while space (DEPTH - occupancy + popped this cycle) remains; excess lanes are dropped.
REQ-023 SHALL, on br_flush, load head <= rollback_head, overriding any same-cycle pop; same-cycle releases still commit to tail.
REQ-024 SHALL wrap all pointer arithmetic modulo 2*DEPTH; queue index is pointer low ADDR_WIDTH bits.
REQ-025 SHALL drive head_out directly from the head register.

Reset
REQ-026 SHALL on rst set head=0, tail=DEPTH (wrap bit 1, low bits 0), queue[i]=RESET_BASE+i for all i.
REQ-027 SHALL after reset present fl_full=1, fl_empty=0, deq_grant=1, deq_preg all 0.
REQ-028 SHALL let rst take priority over br_flush, pops and releases in the same cycle, including mid-operation.

Configuration
REQ-029 SHALL provide macro FREE_LIST_COUNT_EN; when defined, an extra output free_count (ADDR_WIDTH+1 bits) equals occupancy each cycle, reset value DEPTH.
REQ-030 SHALL, without FREE_LIST_COUNT_EN, omit the free_count port; all other behaviour identical.

Verification
REQ-031 SHALL cover reset: assert rst one cycle -> fl_full=1, head_out=0, deq_req=2'b11 yields deq_preg={33,32}, next head_out=2.
REQ-032 SHALL cover sparse request: deq_req=2'b10 after reset -> lane1 gets 32, lane0 reads 0, head advances by 1.
REQ-033 SHALL cover insufficient supply: drain to occupancy 1, deq_req=2'b11 -> deq_grant=0, head unchanged, both deq_preg=0.
REQ-034 SHALL cover wrap: 32 pops then enq_valid=2'b11 with {5,7} -> tail low bits wrap to 0 then 2, next pops return 7 (lane0? no: lane0 gets 7? lane0 first entry) lane0=7, lane1=5 ordering per packed rank.
REQ-035 SHALL cover flush: capture head_out=4, pop 6, br_flush with rollback_head=4 while enqueuing 9 -> head=4, tail+1, registers 36..37 reallocated first.
REQ-036 SHALL cover empty with simultaneous release: occupancy 0, enq 12 and deq_req=2'b01 same cycle -> deq_grant=0, next cycle deq_preg lane0=12.
